seg_scan_decoder: RTL

- Receive-side counterpart of the board's 8-digit multiplexed 7-segment driver.
- Samples the scanned `which`/`seg` bus, filters glitches, decodes each glyph back to a hex nibble, and reassembles the full 32-bit word plus decimal points.
- Used in self-check benches and on-board loopback to confirm that the displayed register/PC value equals the value the datapath produced.

---
 rtl/seg_scan_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Decodes a scanned 8-digit active-low 7-segment bus back into a 32-bit word and decimal points.
// Optional macro DEC_TIMEOUT_EN drops partial frames after TIMEOUT idle cycles.
module seg_scan_decoder #(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    output logic [31:0] data_out,
    output logic [7:0]  dp_out,
    output logic        valid,
    output logic        glyph_err,
    output logic        all8,
    output logic        timeout
);
    localparam int CW = $clog2(STABLE_CYC + 1);

    if (STABLE_CYC < 2 || TIMEOUT < 1) begin : g_param_err
        $error("seg_scan_decoder: STABLE_CYC must be >= 2 and TIMEOUT >= 1");
    end

    logic [2:0]    s_which_reg, p_which_reg;
    logic [7:0]    s_seg_reg, p_seg_reg;
    logic [CW-1:0] stab_cnt_reg;
    logic [7:0]    mask_reg, mask_next;
    logic [31:0]   shadow_reg, shadow_next;
    logic [7:0]    shadow_dp_reg, shadow_dp_next;
    logic          err_reg, err_next;
    logic [31:0]   data_out_reg;
    logic [7:0]    dp_out_reg;
    logic          valid_reg, glyph_err_reg, all8_reg, timeout_reg;
    logic          blank, same, accept, complete, expire;
    logic [4:0]    dec;
    logic [7:0]    digit_sel;

    // Returns {decodable, nibble} for a gfedcba pattern with lit segments as 1.
    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'h3F: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5B: decode = 5'h12;
            7'h4F: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6D: decode = 5'h15;
            7'h7D: decode = 5'h16;
            7'h07: decode = 5'h17;
            7'h7F: decode = 5'h18;
            7'h6F: decode = 5'h19;
            7'h77: decode = 5'h1A;
            7'h7C: decode = 5'h1B;
            7'h39: decode = 5'h1C;
            7'h5E: decode = 5'h1D;
            7'h79: decode = 5'h1E;
            7'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign dec      = decode(~s_seg_reg[6:0]);
    assign blank    = (s_seg_reg[6:0] == 7'h7F);
    assign same     = (s_which_reg == p_which_reg) && (s_seg_reg == p_seg_reg);
    // Counter can only reach STABLE_CYC by stepping up from STABLE_CYC-1 on a matching sample.
    assign accept   = !blank && same && (stab_cnt_reg == CW'(STABLE_CYC - 1));
    assign complete = (mask_reg == 8'hFF);

    for (genvar gi = 0; gi < 8; gi++) begin : g_sel
        assign digit_sel[gi] = accept && (s_which_reg == 3'(gi));
    end

    always_comb begin
        mask_next      = complete ? 8'h00 : mask_reg;
        err_next       = complete ? 1'b0 : err_reg;
        shadow_next    = shadow_reg;
        shadow_dp_next = shadow_dp_reg;
        for (int k = 0; k < 8; k++) begin
            if (digit_sel[k]) begin
                shadow_next[4*k +: 4] = dec[4] ? dec[3:0] : 4'h0;
                shadow_dp_next[k]     = ~s_seg_reg[7];
            end
        end
        mask_next = mask_next | digit_sel;
        if (accept && !dec[4]) begin
            err_next = 1'b1;
        end
        if (expire) begin
            mask_next = 8'h00;
            err_next  = 1'b0;
        end
    end

`ifdef DEC_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt_reg;

    assign expire = !accept && !complete && (mask_reg != 8'h00)
                    && (idle_cnt_reg == IW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (Rst) begin
            idle_cnt_reg <= '0;
        end else if (accept || (mask_reg == 8'h00) || expire) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_reg + IW'(1);
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (Rst) begin
            // Sample registers reset to "blank" so no phantom digit is counted after reset.
            s_which_reg   <= 3'd0;
            s_seg_reg     <= 8'hFF;
            p_which_reg   <= 3'd0;
            p_seg_reg     <= 8'hFF;
            stab_cnt_reg  <= '0;
            mask_reg      <= 8'h00;
            shadow_reg    <= 32'h0;
            shadow_dp_reg <= 8'h00;
            err_reg       <= 1'b0;
            data_out_reg  <= 32'h0;
            dp_out_reg    <= 8'h00;
            valid_reg     <= 1'b0;
            glyph_err_reg <= 1'b0;
            all8_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            s_which_reg <= which;
            s_seg_reg   <= seg;
            if (!blank) begin
                p_which_reg <= s_which_reg;
                p_seg_reg   <= s_seg_reg;
                if (!same) begin
                    stab_cnt_reg <= CW'(1);
                end else if (stab_cnt_reg != CW'(STABLE_CYC)) begin
                    stab_cnt_reg <= stab_cnt_reg + CW'(1);
                end
            end
            mask_reg      <= mask_next;
            shadow_reg    <= shadow_next;
            shadow_dp_reg <= shadow_dp_next;
            err_reg       <= err_next;
            valid_reg     <= complete;
            timeout_reg   <= expire;
            if (complete) begin
                data_out_reg  <= shadow_reg;
                dp_out_reg    <= shadow_dp_reg;
                glyph_err_reg <= err_reg;
                all8_reg      <= (shadow_reg == 32'h88888888) && (shadow_dp_reg == 8'hFF);
            end
        end
    end

    assign data_out  = data_out_reg;
    assign dp_out    = dp_out_reg;
    assign valid     = valid_reg;
    assign glyph_err = glyph_err_reg;
    assign all8      = all8_reg;
    assign timeout   = timeout_reg;
endmodule
